// File: rtl/prores_enc_pkg.sv
// Shared constants and FSM state type for the ProRes encoder DC/VLC path.
package prores_enc_pkg;

    localparam int unsigned MAX_BLOCK_NUM    = 32;
    localparam int unsigned PIXELS_PER_BLOCK = 64;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WT   = 3'd2,
        ST_OUT  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/dc_vlc_sequencer.sv
// Walks the DC word of each block in a slice out of coefficient memory to the VLC encoder.
// Optional feature: define DC_DELTA_EN to emit DC deltas instead of raw DC values.
module dc_vlc_sequencer #(
    parameter int unsigned MAX_BLOCK_NUM    = prores_enc_pkg::MAX_BLOCK_NUM,
    parameter int unsigned PIXELS_PER_BLOCK = prores_enc_pkg::PIXELS_PER_BLOCK
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] block_num,
    output logic        busy,
    output logic        done,
    output logic        mem_rd,
    output logic [10:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        dc_valid,
    input  logic        dc_ready,
    output logic [31:0] dc_data,
    output logic [4:0]  dc_index,
    output logic        dc_first
);

    localparam int unsigned CNT_W = $clog2(MAX_BLOCK_NUM + 1);

    prores_enc_pkg::state_e state_q, state_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             mem_rd_q, mem_rd_d;
    logic [10:0]      mem_addr_q, mem_addr_d;
    logic             dc_valid_q, dc_valid_d;
    logic [31:0]      dc_data_q, dc_data_d;
    logic [4:0]       dc_index_q, dc_index_d;
    logic             dc_first_q, dc_first_d;
`ifdef DC_DELTA_EN
    logic [31:0]      prev_dc_q, prev_dc_d;
`endif

    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        count_d    = count_q;
        mem_addr_d = mem_addr_q;
        dc_data_d  = dc_data_q;
        dc_index_d = dc_index_q;
        dc_first_d = dc_first_q;
`ifdef DC_DELTA_EN
        prev_dc_d  = prev_dc_q;
`endif
        case (state_q)
            prores_enc_pkg::ST_IDLE: begin
                if (start) begin
                    if (block_num > 32'(MAX_BLOCK_NUM)) begin
                        count_d = CNT_W'(MAX_BLOCK_NUM);
                    end else begin
                        count_d = CNT_W'(block_num);
                    end
                    idx_d   = '0;
                    state_d = (count_d == '0) ? prores_enc_pkg::ST_DONE : prores_enc_pkg::ST_RD;
                end
            end
            prores_enc_pkg::ST_RD: begin
                state_d = prores_enc_pkg::ST_WT;
            end
            prores_enc_pkg::ST_WT: begin
`ifdef DC_DELTA_EN
                dc_data_d = (idx_q == '0) ? mem_rdata : mem_rdata - prev_dc_q;
                prev_dc_d = mem_rdata;
`else
                dc_data_d = mem_rdata;
`endif
                dc_index_d = 5'(idx_q);
                dc_first_d = (idx_q == '0);
                state_d    = prores_enc_pkg::ST_OUT;
            end
            prores_enc_pkg::ST_OUT: begin
                if (dc_ready) begin
                    if ((idx_q + CNT_W'(1)) < count_q) begin
                        idx_d   = idx_q + CNT_W'(1);
                        state_d = prores_enc_pkg::ST_RD;
                    end else begin
                        state_d = prores_enc_pkg::ST_DONE;
                    end
                end
            end
            prores_enc_pkg::ST_DONE: begin
                state_d = prores_enc_pkg::ST_IDLE;
            end
            default: begin
                state_d = prores_enc_pkg::ST_IDLE;
            end
        endcase

        mem_rd_d   = (state_d == prores_enc_pkg::ST_RD);
        busy_d     = (state_d != prores_enc_pkg::ST_IDLE);
        done_d     = (state_d == prores_enc_pkg::ST_DONE);
        dc_valid_d = (state_d == prores_enc_pkg::ST_OUT);
        if (state_d == prores_enc_pkg::ST_RD) begin
            mem_addr_d = 11'(idx_d * PIXELS_PER_BLOCK);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= prores_enc_pkg::ST_IDLE;
            idx_q      <= '0;
            count_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            dc_valid_q <= 1'b0;
            dc_data_q  <= '0;
            dc_index_q <= '0;
            dc_first_q <= 1'b0;
`ifdef DC_DELTA_EN
            prev_dc_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            dc_valid_q <= dc_valid_d;
            dc_data_q  <= dc_data_d;
            dc_index_q <= dc_index_d;
            dc_first_q <= dc_first_d;
`ifdef DC_DELTA_EN
            prev_dc_q  <= prev_dc_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign mem_rd   = mem_rd_q;
    assign mem_addr = mem_addr_q;
    assign dc_valid = dc_valid_q;
    assign dc_data  = dc_data_q;
    assign dc_index = dc_index_q;
    assign dc_first = dc_first_q;

endmodule

// File: tb/tb_dc_vlc_sequencer.sv
// Randomized bench for dc_vlc_sequencer with a slice-timeline reference model (honours DC_DELTA_EN).
module tb_dc_vlc_sequencer;

    localparam int MAXC = 1024;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] block_num = '0;
    logic        busy, done, mem_rd, dc_valid, dc_first;
    logic        dc_ready = 1'b0;
    logic [10:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [31:0] dc_data;
    logic [4:0]  dc_index;

    dc_vlc_sequencer dut (
        .clock(clock), .reset(reset), .start(start), .block_num(block_num),
        .busy(busy), .done(done), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .dc_valid(dc_valid), .dc_ready(dc_ready),
        .dc_data(dc_data), .dc_index(dc_index), .dc_first(dc_first)
    );

    always #5 clock = ~clock;

    logic [31:0] mem [32];

    // Coefficient memory: DC word of block i lives at i*64; garbage when not read.
    always @(posedge clock) begin
        if (mem_rd) mem_rdata <= mem[mem_addr[10:6]];
        else        mem_rdata <= $urandom;
    end

    int nvec = 0;
    int nerr = 0;

    logic        rdy    [MAXC];
    logic        e_rd   [MAXC];
    logic [10:0] e_addr [MAXC];
    logic        e_val  [MAXC];
    logic [31:0] e_data [MAXC];
    logic [4:0]  e_idx  [MAXC];
    logic        e_first[MAXC];
    logic        e_done [MAXC];
    logic        e_busy [MAXC];

    int          out_cnt, rd_cnt, done_c;
    logic [10:0] last_addr;
    logic [4:0]  last_idx;
    logic [31:0] obs_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_mem_rd", 32'(mem_rd), 0);
        chk("rst_dc_valid", 32'(dc_valid), 0);
        chk("rst_dc_first", 32'(dc_first), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_dc_data", dc_data, 0);
        chk("rst_dc_index", 32'(dc_index), 0);
    endtask

    function automatic logic [31:0] exp_word(input int k);
`ifdef DC_DELTA_EN
        return (k == 0) ? mem[0] : mem[k] - mem[k-1];
`else
        return mem[k];
`endif
    endfunction

    // mode 0: all ready, 1: random ready, 2: block 1 stalled 5 cycles, 3: all ready;
    // modes 2/3 use the known words 100,120,90,90. abort_c>0 resets during that cycle.
    task automatic run_slice(input int bn, input int mode, input int abort_c);
        int n, c, last;
        bit hs;
        n = (bn > 32) ? 32 : bn;
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        if (mode >= 2) begin
            mem[0] = 100; mem[1] = 120; mem[2] = 90; mem[3] = 90;
        end
        for (int i = 0; i < MAXC; i++) begin
            rdy[i]    = (mode == 1 && i < 600) ? ($urandom_range(0, 3) != 0) : 1'b1;
            e_rd[i]   = 0; e_addr[i] = 0; e_val[i] = 0; e_data[i] = 0;
            e_idx[i]  = 0; e_first[i] = 0; e_done[i] = 0; e_busy[i] = 0;
        end
        if (mode == 2) for (int i = 6; i <= 10; i++) rdy[i] = 1'b0;

        // Timeline: each block reads, waits one cycle, then offers until accepted.
        c = 1;
        for (int k = 0; k < n; k++) begin
            e_rd[c] = 1; e_addr[c] = 11'(k * 64); e_busy[c] = 1; e_busy[c+1] = 1;
            c += 2;
            do begin
                e_val[c] = 1; e_data[c] = exp_word(k); e_idx[c] = 5'(k);
                e_first[c] = (k == 0); e_busy[c] = 1;
                hs = rdy[c];
                c++;
            end while (!hs);
        end
        e_done[c] = 1; e_busy[c] = 1;
        last = c + 1;

        out_cnt = 0; rd_cnt = 0; done_c = -1; last_addr = 0; last_idx = 0;
        obs_q.delete();

        @(negedge clock);
        start = 1'b1; block_num = 32'(bn); dc_ready = 1'b0;
        @(posedge clock); #1;
        for (c = 1; c <= last; c++) begin
            dc_ready  = rdy[c];
            start     = (c < last) ? 1'($urandom_range(0, 1)) : 1'b0;
            block_num = $urandom_range(0, 40);
            if (abort_c != 0 && c == abort_c) reset = 1'b1;
            @(negedge clock);
            chk("busy", 32'(busy), 32'(e_busy[c]));
            chk("done", 32'(done), 32'(e_done[c]));
            chk("mem_rd", 32'(mem_rd), 32'(e_rd[c]));
            if (e_rd[c]) chk("mem_addr", 32'(mem_addr), 32'(e_addr[c]));
            chk("dc_valid", 32'(dc_valid), 32'(e_val[c]));
            if (e_val[c]) begin
                chk("dc_data", dc_data, e_data[c]);
                chk("dc_index", 32'(dc_index), 32'(e_idx[c]));
                chk("dc_first", 32'(dc_first), 32'(e_first[c]));
            end
            if (mem_rd) begin rd_cnt++; last_addr = mem_addr; end
            if (dc_valid && dc_ready) begin
                out_cnt++; last_idx = dc_index; obs_q.push_back(dc_data);
            end
            if (done) done_c = c;
            @(posedge clock); #1;
            if (abort_c != 0 && c == abort_c) break;
        end
        start = 1'b0; dc_ready = 1'b0;
        if (abort_c != 0) begin
            @(negedge clock);
            chk_reset_state();
            reset = 1'b0;
        end
    endtask

    initial begin
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk_reset_state();
        reset = 1'b0;
        @(negedge clock);

        // Known four-block slice: reads at 0,64,128,192, done 13 cycles after start.
        run_slice(4, 3, 0);
        chk("lit_done_cycle", 32'(done_c), 13);
        chk("lit_out_cnt4", 32'(out_cnt), 4);
        chk("lit_rd_cnt4", 32'(rd_cnt), 4);
        chk("lit_last_addr4", 32'(last_addr), 192);
        if (obs_q.size() == 4) begin
`ifdef DC_DELTA_EN
            chk("lit_out0", obs_q[0], 100);
            chk("lit_out1", obs_q[1], 20);
            chk("lit_out2", obs_q[2], 32'hFFFF_FFE2);
            chk("lit_out3", obs_q[3], 0);
`else
            chk("lit_out0", obs_q[0], 100);
            chk("lit_out1", obs_q[1], 120);
            chk("lit_out2", obs_q[2], 90);
            chk("lit_out3", obs_q[3], 90);
`endif
        end

        // Empty slice.
        run_slice(0, 0, 0);
        chk("lit_done0", 32'(done_c), 1);
        chk("lit_rd0", 32'(rd_cnt), 0);
        chk("lit_out0cnt", 32'(out_cnt), 0);

        // Oversized slice saturates at 32 blocks.
        run_slice(40, 0, 0);
        chk("lit_out40", 32'(out_cnt), 32);
        chk("lit_addr40", 32'(last_addr), 1984);
        chk("lit_idx40", 32'(last_idx), 31);

        // Five-cycle stall on block 1.
        run_slice(4, 2, 0);
        chk("lit_done_stall", 32'(done_c), 18);
        chk("lit_rd_stall", 32'(rd_cnt), 4);

        // Reset in the OUT cycle of block 2, then a fresh two-block slice.
        run_slice(4, 3, 9);
        run_slice(2, 3, 0);
        chk("lit_out_after_rst", 32'(out_cnt), 2);
        if (obs_q.size() == 2) begin
            chk("lit_first_raw", obs_q[0], 100);
`ifdef DC_DELTA_EN
            chk("lit_second", obs_q[1], 20);
`else
            chk("lit_second", obs_q[1], 120);
`endif
        end

        // Random slices with random back-pressure.
        for (int s = 0; s < 8; s++) run_slice($urandom_range(0, 40), 1, 0);
        run_slice(32, 1, 0);
        run_slice(1, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/dc_vlc_sequencer.md
DC_VLC_SEQUENCER -- requirements
Module: dc_vlc_sequencer

Interface
REQ-001 Parameter MAX_BLOCK_NUM, default 32: maximum blocks per slice.
REQ-002 Parameter PIXELS_PER_BLOCK, default 64: coefficient stride between block DC words.
REQ-003 Port clock, input, 1: single clock; all logic SHALL be rising-edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port start, input, 1: one-cycle pulse that begins a slice.
REQ-006 Port block_num, input, 32: blocks in the slice; sampled only on accepted start.
REQ-007 Port busy, output, 1: high from accepted start until done.
REQ-008 Port done, output, 1: one-cycle pulse at slice end.
REQ-009 Port mem_rd, output, 1: coefficient-memory read strobe.
REQ-010 Port mem_addr, output, 11: word address = block index * PIXELS_PER_BLOCK.
REQ-011 Port mem_rdata, input, 32: read data, valid exactly one cycle after mem_rd.
REQ-012 Port dc_valid, output, 1: DC word available to the VLC encoder.
REQ-013 Port dc_ready, input, 1: VLC encoder accepts the DC word.
REQ-014 Port dc_data, output, 32: DC value, or delta when DC_DELTA_EN is defined.
REQ-015 Port dc_index, output, 5: block index of dc_data.
REQ-016 Port dc_first, output, 1: high while dc_data belongs to block 0.

Function
REQ-017 The FSM SHALL have states IDLE, RD, WT, OUT and DONE.
REQ-018 In IDLE, start=1 SHALL latch count = min(block_num, MAX_BLOCK_NUM), clear idx to 0, and go to RD; if count is 0, it SHALL go to DONE instead.
REQ-019 In RD, mem_rd=1 and mem_addr=idx*PIXELS_PER_BLOCK for exactly one cycle; next state WT.
REQ-020 In WT, mem_rdata SHALL be captured into dc_data (REQ-027/028); next state OUT.
REQ-021 In OUT, dc_valid=1; dc_data, dc_index and dc_first SHALL stay stable until dc_valid&&dc_ready.
REQ-022 On handshake in OUT: if idx+1 < count, idx increments and the next state is RD; otherwise the next state is DONE.
REQ-023 DONE SHALL assert done for one cycle, then return to IDLE; busy=0 in IDLE only.
REQ-024 Latency: with start accepted at edge N, mem_rd is high in cycle N+1 and dc_valid first rises in cycle N+3; the minimum period is 3 cycles per block.
REQ-025 start while busy SHALL be ignored; block_num changes while busy SHALL have no effect.
REQ-026 mem_rd SHALL be 0 in every state except RD; mem_addr SHALL hold its last value otherwise.

Reset
REQ-027 With reset=1 at an edge, state=IDLE and busy, done, mem_rd, dc_valid, dc_first=0, with mem_addr, dc_data, dc_index, idx, count and prev_dc=0; this applies from any state, including mid-slice, and discards the in-flight block.

Configuration
REQ-028 When macro DC_DELTA_EN is defined, dc_data SHALL be mem_rdata for block 0 and mem_rdata - prev_dc (32-bit two's-complement wrap) for later blocks, with prev_dc updated to the raw mem_rdata on each capture; when it is undefined, dc_data = raw mem_rdata and the prev_dc register is absent.

Structure
REQ-029 A shared package prores_enc_pkg SHALL hold MAX_BLOCK_NUM, PIXELS_PER_BLOCK and the FSM state enum typedef.
REQ-030 The block SHALL be a single module with no sub-modules; the coefficient memory is external.

Verification
REQ-031 block_num=4, DC words 100,120,90,90, dc_ready=1, delta off: reads at 0,64,128,192; outputs 100,120,90,90; done 13 cycles after start.
REQ-032 Same stimulus with DC_DELTA_EN: outputs 100,20,-30 (0xFFFFFFE2),0; dc_first=1 only on the first output.
REQ-033 block_num=0: no mem_rd, no dc_valid; done one cycle after start; busy high for that one cycle only.
REQ-034 block_num=40: exactly 32 outputs, last mem_addr=1984, dc_index=31.
REQ-035 dc_ready low for 5 cycles on block 1: dc_data/dc_index are stable, no extra mem_rd, and the total slice time grows by 5 cycles.
REQ-036 reset asserted in OUT of block 2 of 4, then released, then start issued with block_num=2: outputs only for blocks 0 and 1 of the new slice, and the first output is raw in delta mode.
